// File: rtl/image_stream_reader.sv
// image_stream_reader: snapshots the 32x32 paint bitmap during vertical
// blanking and streams it row-major, one pixel per valid/ready handshake.
//
// Ports:
//   clkVga  - VGA pixel clock, all logic on its rising edge
//   iRstN   - asynchronous active-low reset
//   iStart  - single-cycle capture request, ignored while busy
//   iVs     - active-low vertical sync (same clock domain)
//   iImage  - live bitmap, bit index = x*IMG_H + y
//   oPixel  - current pixel
//   oValid  - oPixel is valid
//   iReady  - downstream accepts the pixel
//   oFirst  - beat is pixel (0,0)
//   oLast   - beat is pixel (IMG_W-1, IMG_H-1)
//   oBusy   - not idle
//   oDone   - one-cycle pulse after the last handshake
//   oCount  - number of 1-pixels transferred in current/last frame
module image_stream_reader #(
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int WAIT_VSYNC = 1
) (
    input  logic                               clkVga,
    input  logic                               iRstN,
    input  logic                               iStart,
    input  logic                               iVs,
    input  logic [IMG_W*IMG_H-1:0]             iImage,
    output logic                               oPixel,
    output logic                               oValid,
    input  logic                               iReady,
    output logic                               oFirst,
    output logic                               oLast,
    output logic                               oBusy,
    output logic                               oDone,
    output logic [$clog2(IMG_W*IMG_H):0]       oCount
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW   = $clog2(NPIX) + 1;

    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]      state;
    logic [1:0]      state_n;
    logic [NPIX-1:0] snap;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic            vs_d;
    logic            vs_fall;
    logic            snap_now;
    logic            handshake;
    logic            at_first;
    logic            at_last;
    logic            snap_bit;

    assign vs_fall = vs_d & ~iVs;

    // Capture on the vsync falling edge so the copy never straddles a
    // painter update; the free-running mode captures right away.
    assign snap_now = (state == S_WAIT) &&
                      ((WAIT_VSYNC == 0) || vs_fall);

    assign at_first = (x == '0) && (y == '0);
    assign at_last  = (x == X_MAX) && (y == Y_MAX);
    assign snap_bit = snap[{x, y}];

    assign oValid    = (state == S_STREAM);
    assign oPixel    = oValid & snap_bit;
    assign oFirst    = oValid & at_first;
    assign oLast     = oValid & at_last;
    assign oBusy     = (state != S_IDLE);
    assign oDone     = (state == S_DONE);
    assign handshake = oValid & iReady;

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (iStart) state_n = S_WAIT;
            end
            S_WAIT: begin
                if (snap_now) state_n = S_STREAM;
            end
            S_STREAM: begin
                if (handshake && at_last) state_n = S_DONE;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN) begin
            state  <= S_IDLE;
            vs_d   <= 1'b1;
            snap   <= '0;
            x      <= '0;
            y      <= '0;
            oCount <= '0;
        end else begin
            state <= state_n;
            vs_d  <= iVs;
            if (snap_now) begin
                snap   <= iImage;
                x      <= '0;
                y      <= '0;
                oCount <= '0;
            end else if (handshake) begin
                oCount <= oCount + CW'(oPixel);
                x      <= x + XW'(1);
                // x is the inner index; y advances on x wrap.
                if (x == X_MAX) y <= y + YW'(1);
            end
        end
    end

endmodule

// File: tb/tb_image_stream_reader.sv
// tb_image_stream_reader: randomized self-checking bench comparing the
// reader against a row-major reference model of the captured bitmap.
module tb_image_stream_reader;

    localparam int IMG_W = 32;
    localparam int IMG_H = 32;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int CW    = $clog2(NPIX) + 1;

    logic            clk;
    logic            rst_n;
    logic            start0;
    logic            start1;
    logic            vs;
    logic            ready;
    logic [NPIX-1:0] image;

    logic          pixel0, valid0, first0, last0, busy0, done0;
    logic          pixel1, valid1, first1, last1, busy1, done1;
    logic [CW-1:0] count0, count1;

    bit sel;

    int checks = 0;
    int errors = 0;

    image_stream_reader #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .WAIT_VSYNC(0)
    ) dut0 (
        .clkVga(clk), .iRstN(rst_n), .iStart(start0), .iVs(vs),
        .iImage(image), .oPixel(pixel0), .oValid(valid0),
        .iReady(ready), .oFirst(first0), .oLast(last0),
        .oBusy(busy0), .oDone(done0), .oCount(count0)
    );

    image_stream_reader #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .WAIT_VSYNC(1)
    ) dut1 (
        .clkVga(clk), .iRstN(rst_n), .iStart(start1), .iVs(vs),
        .iImage(image), .oPixel(pixel1), .oValid(valid1),
        .iReady(ready), .oFirst(first1), .oLast(last1),
        .oBusy(busy1), .oDone(done1), .oCount(count1)
    );

    wire          s_pixel = sel ? pixel1 : pixel0;
    wire          s_valid = sel ? valid1 : valid0;
    wire          s_first = sel ? first1 : first0;
    wire          s_last  = sel ? last1  : last0;
    wire          s_busy  = sel ? busy1  : busy0;
    wire          s_done  = sel ? done1  : done0;
    wire [CW-1:0] s_count = sel ? count1 : count0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input bit v);
        if (sel) start1 = v;
        else     start0 = v;
    endtask

    // Reference: beat n carries pixel (n mod W, n div W), stored at
    // bit x*H + y of the image captured at snapshot time.
    function automatic logic ref_pix(input logic [NPIX-1:0] img,
                                     input int n);
        return img[(n % IMG_W) * IMG_H + n / IMG_W];
    endfunction

    task automatic run_stream(input logic [NPIX-1:0] img,
                              input int pct, input bit poke,
                              input int c0,
                              output int first_c, output int done_c);
        int c, beat, bad, bad_hold, ndone;
        bit pend, r;
        logic hp, hf, hl, ep;
        c = c0; beat = 0; bad = 0; bad_hold = 0; ndone = 0;
        pend = 0; hp = 0; hf = 0; hl = 0;
        first_c = -1;
        while (beat < NPIX && c < c0 + 40000) begin
            r = ($urandom_range(99) < pct);
            ready = r;
            set_start(poke && beat == 100);
            if (s_valid) begin
                if (first_c < 0) first_c = c;
                if (pend && (s_pixel !== hp || s_first !== hf ||
                             s_last !== hl))
                    bad_hold++;
                ep = ref_pix(img, beat);
                if (s_pixel !== ep || s_first !== (beat == 0) ||
                    s_last !== (beat == NPIX - 1))
                    bad++;
                if (beat == 0) chk("first_flag", s_first, 1);
                if (beat == 0 || beat == 32 || beat == NPIX - 1)
                    chk($sformatf("pix%0d", beat), s_pixel, ep);
                if (beat == NPIX - 1) chk("last_flag", s_last, 1);
                hp = s_pixel; hf = s_first; hl = s_last;
                pend = !r;
                if (r) beat++;
            end else if (beat > 0) begin
                bad++;
            end
            step();
            c++;
        end
        ready = 1'b0;
        set_start(1'b0);
        done_c = c;
        chk("beats", beat, NPIX);
        chk("seq", bad, 0);
        chk("hold", bad_hold, 0);
        chk("done", s_done, 1);
        chk("done_valid", s_valid, 0);
        chk("count", s_count, $countones(img));
        if (poke) set_start(1'b1);
        step();
        set_start(1'b0);
        chk("idle", s_busy, 0);
        chk("done_gone", s_done, 0);
        repeat (20) begin
            step();
            if (s_done || s_busy) ndone++;
        end
        chk("no_restart", ndone, 0);
        chk("count_hold", s_count, $countones(img));
    endtask

    task automatic rand_img(output logic [NPIX-1:0] img);
        for (int i = 0; i < NPIX / 32; i++) img[i*32 +: 32] = $urandom;
    endtask

    logic [NPIX-1:0] img;
    int fc, dc, bad_v;

    initial begin
        rst_n = 1'b0; start0 = 0; start1 = 0; vs = 1; ready = 0;
        image = '0; sel = 0;
        step();
        chk("rst_busy", busy0, 0);
        chk("rst_valid", valid0, 0);
        chk("rst_count", count0, 0);
        step();
        rst_n = 1'b1;
        step();

        // basic stream
        img = '0;
        img[0] = 1'b1; img[1] = 1'b1; img[NPIX-1] = 1'b1;
        image = img;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        chk("wait_busy", busy0, 1);
        chk("wait_valid", valid0, 0);
        run_stream(img, 100, 0, 1, fc, dc);
        chk("first_cycle", fc, 2);
        chk("done_cycle", dc, 2 + NPIX);

        // backpressure
        rand_img(img);
        image = img;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        run_stream(img, 50, 0, 1, fc, dc);

        // vsync gating plus post-snapshot image flip
        sel = 1;
        rand_img(img);
        image = img;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        bad_v = 0;
        repeat (499) begin
            if (valid1 || !busy1) bad_v++;
            step();
        end
        chk("vs_wait", bad_v, 0);
        vs = 1'b0;
        chk("vs_fall_valid", valid1, 0);
        step();
        chk("vs_next_valid", valid1, 1);
        image = ~img;
        vs = 1'b1;
        run_stream(img, 100, 0, 0, fc, dc);
        sel = 0;

        // ignored starts mid-stream and during DONE
        rand_img(img);
        image = img;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        run_stream(img, 70, 1, 1, fc, dc);

        // all-ones then all-zero count
        img = '1;
        image = img;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        run_stream(img, 100, 0, 1, fc, dc);
        chk("ones_count", count0, NPIX);
        image = '0;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        chk("pre_snap_count", count0, NPIX);
        step();
        chk("zero_count", count0, 0);
        run_stream('0, 100, 0, 2, fc, dc);

        // reset mid-stream
        img = '1;
        image = img;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        ready = 1'b1;
        repeat (40) step();
        chk("pre_rst_valid", valid0, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_valid_now", valid0, 0);
        chk("rst_pixel_now", pixel0, 0);
        chk("rst_first_now", first0, 0);
        chk("rst_last_now", last0, 0);
        chk("rst_busy_now", busy0, 0);
        chk("rst_done_now", done0, 0);
        chk("rst_count_now", count0, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", busy0, 0);
        repeat (5) step();
        chk("post_rst_valid", valid0, 0);
        chk("post_rst_done", done0, 0);
        ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
